// File: rtl/wallace_mult_pkg.sv
// Shared constants, sign-mode type and Wallace tree sizing helpers for wallace_mult_pipe.
package wallace_mult_pkg;

  localparam int LATENCY = 3;

  // Packed as {a_signed, b_signed}
  typedef enum logic [1:0] {
    MODE_UU = 2'b00,
    MODE_US = 2'b01,
    MODE_SU = 2'b10,
    MODE_SS = 2'b11
  } sign_mode_t;

  // Rows left after one level of 3:2 compression; leftover rows pass through.
  function automatic int wallace_next_height(input int h);
    if (h <= 2) return h;
    return 2 * (h / 3) + (h % 3);
  endfunction

  function automatic int wallace_height(input int h, input int lvl);
    int c;
    c = h;
    for (int i = 0; i < lvl; i++) c = wallace_next_height(c);
    return c;
  endfunction

  function automatic int wallace_stages(input int h);
    int c;
    int n;
    c = h;
    n = 0;
    while (c > 2) begin
      c = wallace_next_height(c);
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// Row of full adders compressing three N-bit vectors into a sum vector and a left-shifted carry vector.
module wallace_csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] w,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  logic [N-2:0] maj;

  // The majority of the top column would shift out of range, so it is never formed.
  assign sum   = x ^ y ^ w;
  assign maj   = (x[N-2:0] & y[N-2:0]) | (x[N-2:0] & w[N-2:0]) | (y[N-2:0] & w[N-2:0]);
  assign carry = {maj, 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier with per-operand signedness and valid/ready flow control.
// Optional feature: define WALLACE_MULT_ACC_EN to add acc_clr and an accumulating output register.
module wallace_mult_pipe
  import wallace_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
`ifdef WALLACE_MULT_ACC_EN
  input  logic               acc_clr,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
);

  localparam int PW   = 2 * WIDTH;
  localparam int NPP  = PW;
  localparam int NLVL = wallace_stages(NPP);

  logic       advance;
  sign_mode_t mode;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] pp_in [NPP];
  logic [PW-1:0] s1_pp [NPP];
  logic [PW-1:0] lvl [NLVL+1][NPP];
  logic [PW-1:0] s2_sum;
  logic [PW-1:0] s2_carry;
  logic [PW-1:0] product;
  logic          s1_valid;
  logic          s2_valid;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign mode  = sign_mode_t'({a_signed, b_signed});
  assign a_ext = mode[1] ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign b_ext = mode[0] ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};

  // Products are taken modulo 2^PW, so rows beyond PW columns are simply truncated.
  for (genvar i = 0; i < NPP; i++) begin : g_pp
    assign pp_in[i] = b_ext[i] ? (a_ext << i) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < NPP; i++) s1_pp[i] <= pp_in[i];
    end
  end

  for (genvar i = 0; i < NPP; i++) begin : g_lvl0
    assign lvl[0][i] = s1_pp[i];
  end

  // Each level compresses groups of three rows; leftover rows pass through, unused slots are zero.
  for (genvar l = 0; l < NLVL; l++) begin : g_level
    localparam int H = wallace_height(NPP, l);
    localparam int G = H / 3;
    localparam int R = H % 3;
    for (genvar g = 0; g < G; g++) begin : g_csa
      wallace_csa_row #(.N(PW)) u_row (
        .x     (lvl[l][3*g]),
        .y     (lvl[l][3*g+1]),
        .w     (lvl[l][3*g+2]),
        .sum   (lvl[l+1][2*g]),
        .carry (lvl[l+1][2*g+1])
      );
    end
    for (genvar r = 2 * G; r < NPP; r++) begin : g_pass
      if (r < 2 * G + R) begin : g_keep
        assign lvl[l+1][r] = lvl[l][3*G + r - 2*G];
      end else begin : g_zero
        assign lvl[l+1][r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s2_sum   <= lvl[NLVL][0];
      s2_carry <= lvl[NLVL][1];
    end
  end

  assign product = s2_sum + s2_carry;

`ifdef WALLACE_MULT_ACC_EN
  logic s1_clr;
  logic s2_clr;

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_clr <= acc_clr;
      s2_clr <= s1_clr;
    end
  end

  // Only a valid beat leaving S2 touches the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      z <= '0;
    end else if (advance && s2_valid) begin
      z <= s2_clr ? product : z + product;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      z <= '0;
    end else if (advance && s2_valid) begin
      z <= product;
    end
  end
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe (WIDTH=8) using an in-order expected-result queue.
// Define WALLACE_MULT_ACC_EN to also exercise the accumulator build.
module tb_wallace_mult_pipe;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           a_signed;
  logic           b_signed;
  logic           acc_clr;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] z;

  int checks = 0;
  int passes = 0;
  logic [2*W-1:0] sb[$];

  always #5 clk = ~clk;

  wallace_mult_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
`ifdef WALLACE_MULT_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic xs, input logic ys);
    longint ex;
    longint ey;
    longint p;
    ex = xs ? longint'($signed(x)) : longint'(x);
    ey = ys ? longint'($signed(y)) : longint'(y);
    p  = ex * ey;
    return p[2*W-1:0];
  endfunction

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic xs, input logic ys, input logic clr);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    a_signed = xs;
    b_signed = ys;
    acc_clr  = clr;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
    else passes++;
    checks++;
    if (z !== '0) $display("[TB] FAIL reset_z got %h want 0000", z);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
    else passes++;
  endtask

  task automatic test_directed();
    logic [W-1:0]   va  [5] = '{8'hFF, 8'h80, 8'h7F, 8'hFD, 8'hFD};
    logic [W-1:0]   vb  [5] = '{8'hFF, 8'h80, 8'h81, 8'hC8, 8'hC8};
    logic           vas [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic           vbs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2*W-1:0] vz  [5] = '{16'hFE01, 16'h4000, 16'hC0FF, 16'hFDA8, 16'hC5A8};
    logic [2*W-1:0] exp_z;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 applyStimulus(va[k], vb[k], vas[k], vbs[k], 1'b1);
      sb.push_back(vz[k]);
      @(posedge clk);
      #1 in_valid = 1'b0;
      // Capture edge plus two more edges before the product is presented.
      for (int e = 0; e < 2; e++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL directed%0d_early_valid edge%0d got %b want 0", k, e + 1, out_valid);
        else passes++;
        @(posedge clk);
      end
      @(negedge clk);
      exp_z = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || z !== exp_z)
        $display("[TB] FAIL directed%0d_product got valid=%b z=%h want valid=1 z=%h", k, out_valid, z, exp_z);
      else passes++;
    end
  endtask

`ifdef WALLACE_MULT_ACC_EN
  task automatic test_accumulate();
    logic [W-1:0]   va  [4] = '{8'd3, 8'd5, 8'hFE, 8'd1};
    logic [W-1:0]   vb  [4] = '{8'd4, 8'd6, 8'd7, 8'd1};
    logic           vas [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic           vcl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2*W-1:0] vz  [4] = '{16'h000C, 16'h002A, 16'h001C, 16'h0001};
    logic [2*W-1:0] exp_z;
    int wait_cyc;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 applyStimulus(va[k], vb[k], vas[k], 1'b0, vcl[k]);
      sb.push_back(vz[k]);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_cyc = 0;
      @(negedge clk);
      while (!out_valid && wait_cyc < 10) begin
        @(negedge clk);
        wait_cyc++;
      end
      exp_z = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || z !== exp_z)
        $display("[TB] FAIL acc%0d got valid=%b z=%h want valid=1 z=%h", k, out_valid, z, exp_z);
      else passes++;
    end
  endtask
`endif

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic accepted;
    logic prev_stall = 1'b0;
    logic [2*W-1:0] prev_z = '0;
    logic [2*W-1:0] exp_z;
    @(posedge clk);
    #1 applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    while ((sent < 100 || recv < 100) && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || z !== prev_z)
          $display("[TB] FAIL stall_hold got valid=%b z=%h want valid=1 z=%h", out_valid, z, prev_z);
        else passes++;
      end
      prev_stall = out_valid && !out_ready;
      prev_z     = z;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("[TB] FAIL stream_unexpected got z=%h want no output", z);
        end else begin
          exp_z = sb.pop_front();
          if (z !== exp_z) $display("[TB] FAIL stream_beat%0d got %h want %h", recv, z, exp_z);
          else passes++;
        end
        recv++;
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        sb.push_back(ref_mul(a, b, a_signed, b_signed));
        sent++;
      end
      @(posedge clk);
      #1 cyc++;
      if (accepted) begin
        if (sent < 100) applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        else in_valid = 1'b0;
      end
    end
    checks++;
    if (sent != 100 || recv != 100 || sb.size() != 0)
      $display("[TB] FAIL stream_count got sent=%0d recv=%0d pending=%0d want 100 100 0", sent, recv, sb.size());
    else passes++;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    logic [2*W-1:0] exp_z;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 applyStimulus(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0, 1'b0, 1'b1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || z !== '0)
      $display("[TB] FAIL midreset_clear got valid=%b z=%h want valid=0 z=0000", out_valid, z);
    else passes++;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL midreset_stale cycle%0d got %b want 0", e, out_valid);
      else passes++;
    end
    @(posedge clk);
    #1 applyStimulus(8'd12, 8'd11, 1'b0, 1'b0, 1'b1);
    sb.push_back(ref_mul(8'd12, 8'd11, 1'b0, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL midreset_early_valid edge%0d got %b want 0", e + 1, out_valid);
      else passes++;
      @(posedge clk);
    end
    @(negedge clk);
    exp_z = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || z !== exp_z)
      $display("[TB] FAIL midreset_next got valid=%b z=%h want valid=1 z=%h", out_valid, z, exp_z);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_directed();
`ifdef WALLACE_MULT_ACC_EN
    test_accumulate();
`endif
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
